// File: rtl/fetch_seq_ctrl_pkg.sv
// Shared types and constants for the fetch/commit sequencer.
package fetch_seq_ctrl_pkg;

  localparam int          DEF_XLEN     = 32;
  localparam int          DEF_CNT_W    = 64;
  localparam logic [31:0] DEF_NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RESET_PC     = 32'h8000_0000;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    WAIT   = 3'd2,
    EXEC   = 3'd3,
    MEM    = 3'd4,
    COMMIT = 3'd5,
    FAULT  = 3'd6
  } seq_state_t;

endpackage

// File: rtl/fetch_seq_ctrl_instret_counter.sv
// Retired-instruction up-counter; wraps naturally at 2^W.
module instret_counter #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/fetch_seq_ctrl.sv
// Multi-cycle fetch/execute/commit sequencer driving the PC and register-file write enables.
module fetch_seq_ctrl
  import fetch_seq_ctrl_pkg::*;
#(
  parameter int               XLEN     = DEF_XLEN,
  parameter int               CNT_W    = DEF_CNT_W,
  parameter logic [XLEN-1:0]  NOP_INST = XLEN'(DEF_NOP_INST)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [XLEN-1:0]  pc_now,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [XLEN-1:0]  imem_rdata,
  input  logic             imem_err,
  output logic [XLEN-1:0]  inst,
  output logic             inst_valid,
  input  logic             dec_mem_op,
  output logic             dmem_req,
  input  logic             dmem_done,
  input  logic             dmem_err,
  output logic             pc_reg_en,
  output logic             rf_we_en,
  input  logic             halt_req,
  output logic             halted,
  output logic             fault,
  output logic [XLEN-1:0]  fault_pc,
  output logic [CNT_W-1:0] instret
);

  seq_state_t state, next_state;
  logic       misaligned;

  assign misaligned = (pc_now[1:0] != 2'b00);
  assign imem_addr  = pc_now;
  assign fault      = (state == FAULT);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  always_comb begin
    next_state = state;
    imem_req   = 1'b0;
    inst_valid = 1'b0;
    dmem_req   = 1'b0;
    pc_reg_en  = 1'b0;
    rf_we_en   = 1'b0;
    halted     = 1'b0;
    case (state)
      IDLE: begin
        halted = 1'b1;
        if (!halt_req) next_state = FETCH;
      end
      FETCH: begin
        if (misaligned) begin
          next_state = FAULT;
        end else begin
          imem_req = 1'b1;
          if (imem_gnt) next_state = WAIT;
        end
      end
      // Responses are only honoured here, so a stale rvalid after reset is harmless.
      WAIT: begin
        if (imem_rvalid) next_state = imem_err ? FAULT : EXEC;
      end
      EXEC: begin
        inst_valid = 1'b1;
        next_state = dec_mem_op ? MEM : COMMIT;
      end
      MEM: begin
        dmem_req = 1'b1;
        if (dmem_done) next_state = dmem_err ? FAULT : COMMIT;
      end
      COMMIT: begin
        pc_reg_en  = 1'b1;
        rf_we_en   = 1'b1;
        next_state = halt_req ? IDLE : FETCH;
      end
      FAULT:   next_state = FAULT;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      inst     <= NOP_INST;
      fault_pc <= '0;
    end else begin
      if (state == WAIT && imem_rvalid && !imem_err) begin
        inst <= imem_rdata;
      end else if (state == FAULT) begin
        inst <= NOP_INST;
      end
      if (next_state == FAULT && state != FAULT) begin
        fault_pc <= pc_now;
      end
    end
  end

  instret_counter #(.W(CNT_W)) u_instret (
    .clk   (clk),
    .rst   (rst),
    .en    (state == COMMIT),
    .count (instret)
  );

endmodule

// File: tb/tb_fetch_seq_ctrl.sv
// Directed self-checking bench for fetch_seq_ctrl with a small latency-configurable memory responder.
module tb_fetch_seq_ctrl;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [31:0] pc_now;
  logic        imem_req, imem_gnt, imem_rvalid, imem_err;
  logic [31:0] imem_addr, imem_rdata, inst, fault_pc;
  logic        inst_valid, dec_mem_op, dmem_req, dmem_done, dmem_err;
  logic        pc_reg_en, rf_we_en, halt_req, halted, fault;
  logic [63:0] instret;

  int          checks = 0;
  int          errors = 0;

  int          gnt_lat = 0, rv_lat = 1, dm_lat = 1;
  logic        ierr_cfg = 1'b0, derr_cfg = 1'b0, mem_op_cfg = 1'b0;
  logic [31:0] pc_base = RESET_PC;
  logic [31:0] commits = '0;
  int          req_cnt, rv_cnt, dm_cnt;

  always #5 clk = ~clk;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return a ^ 32'h1234_5693;
  endfunction

  // PC register model advances on each commit; memory answers per the latency knobs.
  always @(posedge clk) if (pc_reg_en) commits <= commits + 32'd1;
  assign pc_now      = pc_base + (commits << 2);
  assign dec_mem_op  = mem_op_cfg;
  assign imem_gnt    = imem_req && (req_cnt == gnt_lat);
  assign imem_rvalid = (rv_cnt == 1);
  assign imem_err    = imem_rvalid && ierr_cfg;
  assign imem_rdata  = inst_of(pc_now);
  assign dmem_done   = dmem_req && (dm_cnt == dm_lat - 1);
  assign dmem_err    = dmem_done && derr_cfg;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      req_cnt <= 0; rv_cnt <= 0; dm_cnt <= 0;
    end else begin
      req_cnt <= (imem_req && !imem_gnt) ? req_cnt + 1 : 0;
      if (imem_gnt) rv_cnt <= rv_lat;
      else if (rv_cnt > 0) rv_cnt <= rv_cnt - 1;
      dm_cnt <= (dmem_req && !dmem_done) ? dm_cnt + 1 : 0;
    end
  end

  fetch_seq_ctrl dut (
    .clk(clk), .rst(rst), .pc_now(pc_now),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .inst(inst), .inst_valid(inst_valid), .dec_mem_op(dec_mem_op),
    .dmem_req(dmem_req), .dmem_done(dmem_done), .dmem_err(dmem_err),
    .pc_reg_en(pc_reg_en), .rf_we_en(rf_we_en), .halt_req(halt_req),
    .halted(halted), .fault(fault), .fault_pc(fault_pc), .instret(instret)
  );

  // After return, the next negedge is cycle 1 (the first FETCH when halt_req is low).
  task automatic do_reset(input logic [31:0] start_pc);
    rst = 1'b0;
    pc_base = start_pc - (commits << 2);
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset;
    halt_req = 1'b0;
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL reset_halted got %b expected 1", halted); end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_imem_req got %b expected 0", imem_req); end
    checks++; if (inst !== NOP) begin errors++; $display("[TB] FAIL reset_inst got %h expected %h", inst, NOP); end
    checks++; if (fault !== 1'b0 || fault_pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_fault got %b/%h expected 0/0", fault, fault_pc); end
    checks++; if (instret !== 64'd0) begin errors++; $display("[TB] FAIL reset_instret got %0d expected 0", instret); end
    checks++; if ({pc_reg_en, rf_we_en, inst_valid, dmem_req} !== 4'b0) begin errors++; $display("[TB] FAIL reset_strobes got %b expected 0000", {pc_reg_en, rf_we_en, inst_valid, dmem_req}); end
    halt_req = 1'b1;
    do_reset(RESET_PC);
    repeat (3) @(negedge clk);
    checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL halt_hold got %b/%b expected 1/0", halted, imem_req); end
    halt_req = 1'b0;
    @(negedge clk);
    checks++; if (imem_req !== 1'b1 || halted !== 1'b0) begin errors++; $display("[TB] FAIL halt_release got %b/%b expected 1/0", imem_req, halted); end
  endtask

  task automatic test_back_to_back;
    logic exp_en;
    gnt_lat = 0; rv_lat = 1; mem_op_cfg = 1'b0; ierr_cfg = 1'b0; halt_req = 1'b0;
    do_reset(RESET_PC);
    for (int n = 1; n <= 13; n++) begin
      @(negedge clk);
      exp_en = (n % 4 == 0) && (n <= 12);
      checks++; if (pc_reg_en !== exp_en || rf_we_en !== exp_en) begin errors++; $display("[TB] FAIL b2b_commit cycle %0d got %b/%b expected %b", n, pc_reg_en, rf_we_en, exp_en); end
      checks++; if (inst_valid !== (n % 4 == 3)) begin errors++; $display("[TB] FAIL b2b_inst_valid cycle %0d got %b expected %b", n, inst_valid, (n % 4 == 3)); end
      if (n == 1) begin
        checks++; if (imem_addr !== RESET_PC || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL b2b_first_fetch got %h/%b expected %h/1", imem_addr, imem_req, RESET_PC); end
      end
      if (n == 7) begin
        checks++; if (inst !== inst_of(32'h8000_0004)) begin errors++; $display("[TB] FAIL b2b_inst2 got %h expected %h", inst, inst_of(32'h8000_0004)); end
      end
      if (n == 13) begin
        checks++; if (instret !== 64'd3) begin errors++; $display("[TB] FAIL b2b_instret got %0d expected 3", instret); end
      end
    end
  endtask

  task automatic test_wait_states;
    int req_seen = 0, valid_seen = 0;
    gnt_lat = 3; rv_lat = 3; mem_op_cfg = 1'b0; halt_req = 1'b0;
    do_reset(RESET_PC);
    for (int n = 1; n <= 9; n++) begin
      @(negedge clk);
      if (imem_req) begin
        req_seen++;
        checks++; if (imem_addr !== RESET_PC) begin errors++; $display("[TB] FAIL ws_addr cycle %0d got %h expected %h", n, imem_addr, RESET_PC); end
      end
      if (inst_valid) begin
        valid_seen++;
        checks++; if (n != 8 || inst !== inst_of(RESET_PC)) begin errors++; $display("[TB] FAIL ws_issue cycle %0d inst %h expected cycle 8 inst %h", n, inst, inst_of(RESET_PC)); end
      end
      if (n == 9) begin
        checks++; if (pc_reg_en !== 1'b1) begin errors++; $display("[TB] FAIL ws_commit got %b expected 1", pc_reg_en); end
      end
    end
    checks++; if (req_seen != 4) begin errors++; $display("[TB] FAIL ws_req_cycles got %0d expected 4", req_seen); end
    checks++; if (valid_seen != 1) begin errors++; $display("[TB] FAIL ws_valid_pulses got %0d expected 1", valid_seen); end
    gnt_lat = 0; rv_lat = 1;
  endtask

  task automatic test_mem_op;
    int dreq_seen = 0, commit_seen = 0;
    gnt_lat = 0; rv_lat = 1; dm_lat = 2; mem_op_cfg = 1'b1; derr_cfg = 1'b0; halt_req = 1'b0;
    do_reset(RESET_PC);
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      if (dmem_req) dreq_seen++;
      if (pc_reg_en) commit_seen++;
      checks++; if (rf_we_en !== pc_reg_en || pc_reg_en !== (n == 6)) begin errors++; $display("[TB] FAIL mem_commit cycle %0d got %b/%b expected %b", n, pc_reg_en, rf_we_en, (n == 6)); end
    end
    checks++; if (dreq_seen != 2) begin errors++; $display("[TB] FAIL mem_dreq_cycles got %0d expected 2", dreq_seen); end
    checks++; if (commit_seen != 1) begin errors++; $display("[TB] FAIL mem_commit_count got %0d expected 1", commit_seen); end
  endtask

  task automatic test_halt;
    gnt_lat = 0; rv_lat = 1; dm_lat = 2; mem_op_cfg = 1'b1; halt_req = 1'b0;
    do_reset(RESET_PC);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 4) halt_req = 1'b1;
      if (n == 6) begin
        checks++; if (pc_reg_en !== 1'b1) begin errors++; $display("[TB] FAIL halt_commit got %b expected 1", pc_reg_en); end
      end
      if (n >= 7 && n <= 9) begin
        checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL halt_idle cycle %0d got %b/%b expected 1/0", n, halted, imem_req); end
      end
      if (n == 7) begin
        checks++; if (instret !== 64'd1) begin errors++; $display("[TB] FAIL halt_instret got %0d expected 1", instret); end
      end
      if (n == 9) halt_req = 1'b0;
      if (n == 10) begin
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h8000_0004) begin errors++; $display("[TB] FAIL halt_resume got %b/%h expected 1/80000004", imem_req, imem_addr); end
      end
    end
    mem_op_cfg = 1'b0;
  endtask

  task automatic test_fetch_err;
    int commit_seen = 0;
    gnt_lat = 0; rv_lat = 1; mem_op_cfg = 1'b0; ierr_cfg = 1'b0; halt_req = 1'b0;
    do_reset(32'h8000_0004);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      if (n == 3) begin
        checks++; if (inst !== inst_of(32'h8000_0004)) begin errors++; $display("[TB] FAIL ferr_first_inst got %h expected %h", inst, inst_of(32'h8000_0004)); end
      end
      if (n == 4) ierr_cfg = 1'b1;
      if (n >= 5 && pc_reg_en) commit_seen++;
      if (n == 7) begin
        checks++; if (fault !== 1'b1 || fault_pc !== 32'h8000_0008) begin errors++; $display("[TB] FAIL ferr_fault got %b/%h expected 1/80000008", fault, fault_pc); end
      end
      if (n == 8) begin
        checks++; if (inst !== NOP || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL ferr_nop got %h/%b expected %h/0", inst, imem_req, NOP); end
      end
    end
    checks++; if (commit_seen != 0) begin errors++; $display("[TB] FAIL ferr_no_commit got %0d expected 0", commit_seen); end
    rst = 1'b0;
    #1;
    checks++; if (fault !== 1'b0 || fault_pc !== 32'h0) begin errors++; $display("[TB] FAIL ferr_clear got %b/%h expected 0/0", fault, fault_pc); end
    ierr_cfg = 1'b0;
  endtask

  task automatic test_misaligned;
    halt_req = 1'b0;
    do_reset(32'h8000_0002);
    for (int n = 1; n <= 4; n++) begin
      @(negedge clk);
      checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL mis_req cycle %0d got %b expected 0", n, imem_req); end
      if (n == 2) begin
        checks++; if (fault !== 1'b1 || fault_pc !== 32'h8000_0002) begin errors++; $display("[TB] FAIL mis_fault got %b/%h expected 1/80000002", fault, fault_pc); end
      end
    end
  endtask

  initial begin
    halt_req = 1'b1;
    test_reset;
    test_back_to_back;
    test_wait_states;
    test_mem_op;
    test_halt;
    test_fetch_err;
    test_misaligned;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fetch_seq_ctrl.md
Name: fetch_seq_ctrl

Overview:
Multi-cycle sequencer for the PC register and its next-PC adder. It fetches the instruction at the current PC over a req/gnt/rvalid instruction-memory handshake and latches it. It holds the instruction stable while the execute stage, and the data-memory stage if needed, completes. It then pulses the PC write-enable and register-file write-enable for exactly one cycle, and it counts retired instructions.

Parameters:
XLEN, 32, datapath and address width
CNT_W, 64, width of retired-instruction counter
NOP_INST, 32'h00000013, instruction value held after reset and fault

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-low
pc_now  in  XLEN  current PC from PC register
imem_req  out  1  fetch request
imem_addr  out  XLEN  fetch address (= pc_now)
imem_gnt  in  1  request accepted this cycle
imem_rvalid  in  1  fetch data valid
imem_rdata  in  XLEN  fetched instruction
imem_err  in  1  fetch bus error (qualifies rvalid cycle)
inst  out  XLEN  latched instruction to decoder
inst_valid  out  1  one-cycle pulse: inst is newly issued
dec_mem_op  in  1  decoder: inst is load/store (sampled in EXEC)
dmem_req  out  1  data-memory access request
dmem_done  in  1  data access complete
dmem_err  in  1  data access error
pc_reg_en  out  1  PC register write enable (commit)
rf_we_en  out  1  register-file write gate (commit)
halt_req  in  1  stop before next fetch
halted  out  1  sequencer idle in IDLE
fault  out  1  sticky fault flag
fault_pc  out  XLEN  PC of faulting instruction
instret  out  CNT_W  retired-instruction count

Behaviour:
- State reg updates on the clk edge; cleared asynchronously on rst low. States: IDLE, FETCH, WAIT, EXEC, MEM, COMMIT, FAULT.
- Reset values: state=IDLE, inst=NOP_INST, fault=0, fault_pc=0, instret=0. All strobes 0.
- Outputs are decoded from state: imem_req (FETCH), inst_valid (EXEC), dmem_req (MEM), pc_reg_en and rf_we_en (COMMIT), halted (IDLE).
- IDLE: if !halt_req go to FETCH next cycle; otherwise stay.
- FETCH: imem_addr=pc_now.
  - If pc_now[1:0]!=0: imem_req is forced 0, fault_pc<=pc_now, go to FAULT.
  - Else imem_req=1 and is held until imem_gnt. On gnt go to WAIT.
- WAIT: rvalid is only honoured here; rvalid in the FETCH gnt cycle is ignored, so memory latency is ≥1.
  - On rvalid&err go to FAULT with fault_pc<=pc_now. Error wins over data.
  - On rvalid&!err: inst<=imem_rdata, go to EXEC.
- EXEC: one cycle. If dec_mem_op go to MEM, else go to COMMIT.
- MEM: dmem_req held until dmem_done.
  - done&err: go to FAULT, fault_pc<=pc_now.
  - done&!err: go to COMMIT.
- COMMIT: one cycle; pc_reg_en=1, rf_we_en=1, instret<=instret+1 (wraps modulo 2^CNT_W). If halt_req go to IDLE, else go to FETCH.
- FAULT: fault=1, inst<=NOP_INST. No strobes are issued. Terminal until reset.
- pc_now must be stable from FETCH through COMMIT. This is guaranteed because pc_reg_en fires only in COMMIT.
- halt_req is sampled only in IDLE and COMMIT; an in-flight instruction always completes.
- Minimum latency for a non-memory instruction with zero-wait memory (gnt in FETCH cycle, rvalid the next cycle): 4 cycles per instruction (FETCH, WAIT, EXEC, COMMIT). With a memory op and 1-cycle dmem_done: 5 cycles.
- Reset mid-operation: all state is discarded immediately. Any outstanding imem or dmem response after reset is ignored, because rvalid is honoured only in WAIT and done only in MEM.

Decomposition:
- Shared package/common header: the XLEN define, the state enum type (seq_state_t), NOP_INST, and the reset-PC constant 32'h80000000.
- One natural sub-module: instret_counter (CNT_W up-counter with enable and async active-low clear).

Test Plan:
- Reset then run 3 non-memory instructions with gnt same cycle and rvalid +1 cycle: pc_reg_en pulses at cycles 4, 8, 12; instret=3; imem_addr=0x80000000 in the first FETCH.
- gnt delayed 3 cycles and rvalid delayed 2 more: imem_req stays high for 4 cycles and addr stays stable; exactly one inst_valid pulse with inst=rdata.
- Load with dec_mem_op=1 and dmem_done after 2 cycles: dmem_req high for 2 cycles; single pc_reg_en after done; rf_we_en coincident with pc_reg_en.
- rvalid with imem_err=1 at pc 0x80000008: fault=1, fault_pc=0x80000008, no pc_reg_en, inst=NOP; rst low then high clears fault.
- pc_now=0x80000002 in FETCH: imem_req never asserted; FAULT entered the next cycle.
- halt_req raised mid-MEM: instruction commits, then halted=1 with no new imem_req; dropping halt_req resumes fetch on the next cycle.
